// File: rtl/conv_code_pkg.sv
// Shared constants for the K=3 rate-1/2 convolutional code, used by both the
// encoder and the decoder side.
package conv_code_pkg;

  localparam int K       = 3;
  localparam int STATE_W = K - 1;
  localparam int CW_W    = 16;
  localparam int BYTE_W  = 8;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ENC  = 1'b1;

  function automatic logic parity3(input logic [K-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Serial 1-bit-in / 2-bit-out K=3 encoder core. Holds the two-bit memory
// {m0,m1}; en_i advances it, clear_i zeroes it.
module conv_enc_core
  import conv_code_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clear_i,
  input  logic       u_i,
  output logic [1:0] code_o
);

  // mem_q[1] is m0 (most recent bit), mem_q[0] is m1
  logic [STATE_W-1:0] mem_q;
  logic [STATE_W-1:0] mem_d;
  logic [K-1:0]       taps_s;

  always_comb begin
    taps_s = {u_i, mem_q};
    code_o = {parity3(G0 & taps_s), parity3(G1 & taps_s)};
    if (en_i) begin
      mem_d = {u_i, mem_q[1]};
    end else if (clear_i) begin
      mem_d = 2'b00;
    end else begin
      mem_d = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= 2'b00;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/conv_encoder_top.sv
// Byte-parallel wrapper around the serial encoder core: accepts a byte,
// encodes it MSB-first over 8 cycles and presents the packed 16-bit code word.
module conv_encoder_top
  import conv_code_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dvalid_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              clear_i,
  output logic [CW_W-1:0]   data_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              overrun_o
);

  logic [0:0]        state_q,   state_d;
  logic [2:0]        cnt_q,     cnt_d;
  logic [BYTE_W-1:0] shreg_q,   shreg_d;
  logic [CW_W-1:0]   cw_q,      cw_d;
  logic [CW_W-1:0]   data_q,    data_d;
  logic              valid_q,   valid_d;
  logic              overrun_q, overrun_d;
  logic              enc_en_s;
  logic              enc_clr_s;
  logic [1:0]        code_s;

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .en_i    (enc_en_s),
    .clear_i (enc_clr_s),
    .u_i     (shreg_q[BYTE_W-1]),
    .code_o  (code_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    cw_d      = cw_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    enc_en_s  = 1'b0;
    enc_clr_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        enc_clr_s = clear_i;
        if (dvalid_i) begin
          state_d = S_ENC;
          shreg_d = data_i;
          cnt_d   = 3'd0;
          cw_d    = 16'h0000;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ENC: begin
        enc_en_s  = 1'b1;
        overrun_d = dvalid_i;
        // {~cnt,1} is 15-2*cnt: symbol for bit cnt lands in [15-2cnt : 14-2cnt]
        cw_d[{~cnt_q, 1'b1} -: 2] = code_s;
        shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_IDLE;
          data_d  = cw_d;
          valid_d = 1'b1;
        end else begin
          state_d = S_ENC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      shreg_q   <= 8'h00;
      cw_q      <= 16'h0000;
      data_q    <= 16'h0000;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      cw_q      <= cw_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == S_ENC);
  assign overrun_o = overrun_q;

endmodule
